dcache_ctrl: RTL and testbench
==============================

// Module: dcache_ctrl
// PURPOSE
//  Direct-mapped, write-back, write-allocate data cache. Sits between the MEM stage (32-bit word
//  requests) and the line-wide `memory` block, acting as that block's sole initiator
//  (addr/wdata/memwrite/memread -> rdata). Stalls the pipeline on miss; hides line traffic.
// PARAMETERS
//  WIDTH    `MEMORY_WIDTH  line width in bits (power of 2, >=64); must match memory WIDTH
//  LINES    16             number of cache lines (power of 2)
//  ADDR     32             byte-address width
//  LATENCY  2              cycles mem_read is held before mem_rdata is sampled (>=1)
// PORTS
//  clk        in   1      clock
//  reset      in   1      synchronous, active-high reset
//  addr       in   ADDR   CPU byte address (word aligned)
//  wdata      in   32     CPU store data
//  memread    in   1      CPU load request
//  memwrite   in   1      CPU store request (wins if both asserted)
//  rdata      out  32     load data, valid when memread && !stall
//  stall      out  1      combinational; request not yet complete, CPU must hold inputs stable
//  mem_addr   out  ADDR   line-aligned address to memory (low WB bits zero, except debug pass-through)
//  mem_wdata  out  WIDTH  line (or debug word in [31:0]) to memory
//  mem_read   out  1      line read strobe
//  mem_write  out  1      line write strobe, exactly one cycle per write
//  mem_rdata  in   WIDTH  line from memory
// BEHAVIOUR
//  - Address split: WB=$clog2(WIDTH)-3 offset bits, word = addr[WB-1:2], IB=$clog2(LINES) index
//    bits addr[IB+WB-1:WB], tag = addr[ADDR-1:IB+WB]. Per line: valid, dirty, tag, data.
//  - Reset: state IDLE, all valid/dirty = 0, counter = 0; rdata, stall, mem_read, mem_write,
//    mem_addr, mem_wdata = 0. Reset mid-WRITEBACK/FILL aborts: no further mem strobes, line
//    left invalid.
//  - States: IDLE, WRITEBACK, FILL, DEBUG.
//  - IDLE, no request: all mem strobes 0, stall 0.
//  - IDLE hit (valid && tag match): load -> rdata = selected word same cycle, stall 0; store ->
//    word written at posedge, dirty <= 1, stall 0. Zero-cycle penalty.
//  - IDLE miss: stall 1 same cycle. Victim valid && dirty -> WRITEBACK, else -> FILL.
//  - WRITEBACK (1 cycle): mem_write 1, mem_addr = {victim tag, index, 0}, mem_wdata = victim
//    line; next FILL. stall 1.
//  - FILL: mem_read 1, mem_addr = {req tag, index, 0}, counter counts 0..LATENCY-1; on
//    count==LATENCY-1 capture mem_rdata into line, tag set, valid 1, dirty 0, -> IDLE. stall 1
//    throughout. Following IDLE cycle re-evaluates as hit (store merges then).
//  - Miss penalty: clean = LATENCY+1 stall cycles; dirty = LATENCY+2.
//  - Debug pass-through: addr >= {ADDR{1'b1}}-1 (0xffffffff, 0xfffffffe) bypasses the cache.
//    Store -> DEBUG: one cycle mem_write 1, mem_addr = addr unmodified, mem_wdata[31:0] = wdata,
//    upper bits 0, stall 1; -> IDLE, then stall 0. Load at 0xffffffff -> mem_read 1 held, stall 1
//    (memory ends simulation). No line state touched.
//  - Back-to-back requests to same line after fill: all hits. Conflict (same index, other tag):
//    evicts, no associativity.
//  - Request deasserted while stalled: illegal; bench asserts it never happens.
//  - rdata = 0 whenever !(memread && hit in IDLE).
// STRUCTURE
//  - State encodings and DCACHE_LINES default go in the shared defines.v include.
//  - One sub-module: dcache_array (valid/dirty/tag/data storage, combinational read, one write
//    port with line-fill or word-merge select). FSM + counter + mux logic stay in dcache_ctrl.
// TESTING (WIDTH=128, LINES=4, LATENCY=2, memory preloaded mem[i] = {4{i}})
//  - Cold load 0x10: stall 3 cycles, one mem_read burst at 0x10, then rdata=0x00000001; repeat
//    load 0x14 -> rdata=0x00000001, stall 0.
//  - Store 0x5a5a5a5a to 0x18 after fill -> no mem traffic, stall 0; load 0x18 -> 0x5a5a5a5a.
//  - Load 0x58 (same index, new tag) after the store -> one mem_write at 0x10 with word2 =
//    0x5a5a5a5a, then mem_read at 0x50, 4 stall cycles, rdata=0x00000005.
//  - Clean conflict miss -> no mem_write, exactly LATENCY+1 stall cycles.
//  - Store 0x41 to 0xfffffffe -> one-cycle mem_write, mem_addr=0xfffffffe, mem_wdata=0x41;
//    cache lines unchanged.
//  - Reset asserted in 2nd FILL cycle -> next cycle all outputs 0, state IDLE; same load misses
//    again.

Source files
------------

// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the data cache controller: FSM encoding and default geometry.
package dcache_ctrl_pkg;

  localparam int MEMORY_WIDTH = 128;
  localparam int DCACHE_LINES = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_FILL,
    S_DEBUG
  } dc_state_e;

endpackage

// File: rtl/dcache_array.sv
// Per-line valid/dirty/tag/data storage with combinational read and a single write port
// that either installs a whole line (fill) or merges one 32-bit word (store hit).
module dcache_array
  import dcache_ctrl_pkg::*;
#(
  parameter int WIDTH = MEMORY_WIDTH,
  parameter int LINES = DCACHE_LINES,
  parameter int TB    = 26
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [$clog2(LINES)-1:0]     idx_i,
  input  logic                         we_i,
  input  logic                         fill_i,
  input  logic [TB-1:0]                tag_i,
  input  logic [WIDTH-1:0]             line_i,
  input  logic [$clog2(WIDTH/32)-1:0]  word_sel_i,
  input  logic [31:0]                  word_i,
  output logic                         valid_o,
  output logic                         dirty_o,
  output logic [TB-1:0]                tag_o,
  output logic [WIDTH-1:0]             line_o
);

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TB-1:0]    tag_q  [LINES];
  logic [WIDTH-1:0] data_q [LINES];

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = data_q[idx_i];

  // Only valid/dirty need clearing; tag/data are ignored until a fill sets valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (we_i) begin
      if (fill_i) begin
        data_q[idx_i]  <= line_i;
        tag_q[idx_i]   <= tag_i;
        valid_q[idx_i] <= 1'b1;
        dirty_q[idx_i] <= 1'b0;
      end else begin
        data_q[idx_i][{word_sel_i, 5'b0} +: 32] <= word_i;
        dirty_q[idx_i] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache between the MEM stage and line memory.
// Misses stall the pipeline; a top-of-address-space window bypasses the cache for debug I/O.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int WIDTH   = MEMORY_WIDTH,
  parameter int LINES   = DCACHE_LINES,
  parameter int ADDR    = 32,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ADDR-1:0]  addr,
  input  logic [31:0]      wdata,
  input  logic             memread,
  input  logic             memwrite,
  output logic [31:0]      rdata,
  output logic             stall,
  output logic [ADDR-1:0]  mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam int WB = $clog2(WIDTH) - 3;
  localparam int IB = $clog2(LINES);
  localparam int TB = ADDR - IB - WB;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  dc_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dbg_done_q, dbg_done_d;

  logic [IB-1:0]    req_idx;
  logic [TB-1:0]    req_tag;
  logic [WB-3:0]    req_word;
  logic             req, dbg, hit, fill_last;
  logic             arr_we, arr_fill;
  logic             vic_valid, vic_dirty;
  logic [TB-1:0]    vic_tag;
  logic [WIDTH-1:0] vic_line;

  assign req_word  = addr[WB-1:2];
  assign req_idx   = addr[IB+WB-1:WB];
  assign req_tag   = addr[ADDR-1:IB+WB];
  assign req       = memread | memwrite;
  assign dbg       = addr >= ({ADDR{1'b1}} - ADDR'(1));
  assign hit       = vic_valid && (vic_tag == req_tag);
  assign fill_last = (cnt_q == CW'(LATENCY - 1));

  dcache_array #(
    .WIDTH (WIDTH),
    .LINES (LINES),
    .TB    (TB)
  ) u_array (
    .clk        (clk),
    .reset      (reset),
    .idx_i      (req_idx),
    .we_i       (arr_we),
    .fill_i     (arr_fill),
    .tag_i      (req_tag),
    .line_i     (mem_rdata),
    .word_sel_i (req_word),
    .word_i     (wdata),
    .valid_o    (vic_valid),
    .dirty_o    (vic_dirty),
    .tag_o      (vic_tag),
    .line_o     (vic_line)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dbg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dbg_done_q <= dbg_done_d;
    end
  end

  // dbg_done marks the IDLE cycle after a debug write so the held store completes instead of re-issuing.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    dbg_done_d = (state_q == S_DEBUG);
    unique case (state_q)
      S_IDLE: begin
        if (req && !dbg && !hit)
          state_d = (vic_valid && vic_dirty) ? S_WRITEBACK : S_FILL;
        else if (req && dbg && memwrite && !dbg_done_q)
          state_d = S_DEBUG;
      end
      S_WRITEBACK: state_d = S_FILL;
      S_FILL: begin
        if (fill_last) state_d = S_IDLE;
        else           cnt_d   = cnt_q + CW'(1);
      end
      S_DEBUG: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdata     = '0;
    stall     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    arr_we    = 1'b0;
    arr_fill  = 1'b0;
    if (!reset) begin
      unique case (state_q)
        S_IDLE: begin
          if (req) begin
            if (dbg) begin
              if (memwrite) begin
                stall = !dbg_done_q;
              end else begin
                mem_read = 1'b1;
                mem_addr = addr;
                stall    = 1'b1;
              end
            end else if (hit) begin
              if (memwrite) arr_we = 1'b1;
              else          rdata  = vic_line[{req_word, 5'b0} +: 32];
            end else begin
              stall = 1'b1;
            end
          end
        end
        S_WRITEBACK: begin
          mem_write = 1'b1;
          mem_addr  = {vic_tag, req_idx, {WB{1'b0}}};
          mem_wdata = vic_line;
          stall     = 1'b1;
        end
        S_FILL: begin
          mem_read = 1'b1;
          mem_addr = {req_tag, req_idx, {WB{1'b0}}};
          stall    = 1'b1;
          arr_we   = fill_last;
          arr_fill = 1'b1;
        end
        S_DEBUG: begin
          mem_write = 1'b1;
          mem_addr  = addr;
          mem_wdata = WIDTH'(wdata);
          stall     = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a line-wide memory model preloaded as mem[i] = {4{i}}.
module tb_dcache_ctrl;

  logic         clk;
  logic         reset;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic         memread;
  logic         memwrite;
  logic [31:0]  rdata;
  logic         stall;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         mem_read;
  logic         mem_write;
  logic [127:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  logic [127:0] mem [64];
  int           rd_cnt = 0;
  int           wr_cnt = 0;
  int           viol   = 0;
  logic         stall_seen = 1'b0;
  logic [31:0]  last_raddr = '0;
  logic [31:0]  last_waddr = '0;
  logic [127:0] last_wdata = '0;

  dcache_ctrl #(
    .WIDTH   (128),
    .LINES   (4),
    .ADDR    (32),
    .LATENCY (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .memread   (memread),
    .memwrite  (memwrite),
    .rdata     (rdata),
    .stall     (stall),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = {4{i[31:0]}};
  end

  assign mem_rdata = mem[mem_addr[9:4]];

  always @(posedge clk) begin
    if (!reset) begin
      if (mem_read) begin
        rd_cnt     <= rd_cnt + 1;
        last_raddr <= mem_addr;
      end
      if (mem_write) begin
        wr_cnt     <= wr_cnt + 1;
        last_waddr <= mem_addr;
        last_wdata <= mem_wdata;
        if (mem_addr < 32'hffff_fffe) mem[mem_addr[9:4]] <= mem_wdata;
      end
      if (stall_seen && !(memread || memwrite)) begin
        viol <= viol + 1;
        $display("FAIL protocol: request dropped while stalled at %0t", $time);
      end
    end
    stall_seen <= stall && !reset;
  end

  // Issue one request and hold it until stall drops; reports stall cycles and memory traffic.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output int stalls, output logic [31:0] rd_data, output int rds, output int wrs);
    int r0, w0;
    r0 = rd_cnt; w0 = wr_cnt;
    memread = rd; memwrite = wr; addr = a; wdata = d;
    stalls = 0;
    @(negedge clk);
    while (stall && stalls < 40) begin
      stalls++;
      @(negedge clk);
    end
    tests++;
    if (stall !== 1'b0) begin
      fails++;
      $display("FAIL timeout addr=%h: stall still %b after %0d cycles, required 0", a, stall, stalls);
    end
    rd_data = rdata;
    @(posedge clk); #1;
    memread = 1'b0; memwrite = 1'b0;
    rds = rd_cnt - r0;
    wrs = wr_cnt - w0;
  endtask

  task automatic test_reset();
    reset = 1'b1; memread = 1'b0; memwrite = 1'b0; addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({rdata, stall, mem_read, mem_write} !== 35'd0) begin
      fails++; $display("FAIL reset_outs: rdata=%h stall=%b rd=%b wr=%b, required all 0", rdata, stall, mem_read, mem_write);
    end
    tests++;
    if ({mem_addr, mem_wdata} !== 160'd0) begin
      fails++; $display("FAIL reset_mem_bus: addr=%h wdata=%h, required 0", mem_addr, mem_wdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_cold_load();
    int s, r, w; logic [31:0] d;
    do_req(1'b1, 1'b0, 32'h10, '0, s, d, r, w);
    tests++; if (s !== 3) begin fails++; $display("FAIL cold_stall: got %0d, required 3", s); end
    tests++; if (r !== 2 || w !== 0) begin fails++; $display("FAIL cold_traffic: reads=%0d writes=%0d, required 2/0", r, w); end
    tests++; if (last_raddr !== 32'h10) begin fails++; $display("FAIL cold_raddr: got %h, required 00000010", last_raddr); end
    tests++; if (d !== 32'h1) begin fails++; $display("FAIL cold_rdata: got %h, required 00000001", d); end
    do_req(1'b1, 1'b0, 32'h14, '0, s, d, r, w);
    tests++; if (s !== 0 || d !== 32'h1 || r !== 0) begin
      fails++; $display("FAIL hit_0x14: stall=%0d rdata=%h reads=%0d, required 0/00000001/0", s, d, r);
    end
  endtask

  task automatic test_store_hit();
    int s, r, w; logic [31:0] d;
    do_req(1'b0, 1'b1, 32'h18, 32'h5a5a5a5a, s, d, r, w);
    tests++; if (s !== 0 || r !== 0 || w !== 0) begin
      fails++; $display("FAIL store_hit: stall=%0d reads=%0d writes=%0d, required 0/0/0", s, r, w);
    end
    do_req(1'b1, 1'b0, 32'h18, '0, s, d, r, w);
    tests++; if (s !== 0 || d !== 32'h5a5a5a5a) begin
      fails++; $display("FAIL load_after_store: stall=%0d rdata=%h, required 0/5a5a5a5a", s, d);
    end
  endtask

  task automatic test_dirty_conflict();
    int s, r, w; logic [31:0] d;
    do_req(1'b1, 1'b0, 32'h58, '0, s, d, r, w);
    tests++; if (s !== 4) begin fails++; $display("FAIL dirty_stall: got %0d, required 4", s); end
    tests++; if (w !== 1 || last_waddr !== 32'h10) begin
      fails++; $display("FAIL wb_addr: writes=%0d addr=%h, required 1/00000010", w, last_waddr);
    end
    tests++; if (last_wdata !== 128'h00000001_5a5a5a5a_00000001_00000001) begin
      fails++; $display("FAIL wb_data: got %h, required 000000015a5a5a5a0000000100000001", last_wdata);
    end
    tests++; if (r !== 2 || last_raddr !== 32'h50) begin
      fails++; $display("FAIL refill_addr: reads=%0d addr=%h, required 2/00000050", r, last_raddr);
    end
    tests++; if (d !== 32'h5) begin fails++; $display("FAIL dirty_rdata: got %h, required 00000005", d); end
  endtask

  task automatic test_clean_conflict();
    int s, r, w; logic [31:0] d;
    do_req(1'b1, 1'b0, 32'h10, '0, s, d, r, w);
    tests++; if (s !== 3 || w !== 0) begin
      fails++; $display("FAIL clean_miss: stall=%0d writes=%0d, required 3/0", s, w);
    end
    tests++; if (d !== 32'h1) begin fails++; $display("FAIL clean_rdata: got %h, required 00000001", d); end
    do_req(1'b1, 1'b0, 32'h18, '0, s, d, r, w);
    tests++; if (s !== 0 || d !== 32'h5a5a5a5a) begin
      fails++; $display("FAIL wb_roundtrip: stall=%0d rdata=%h, required 0/5a5a5a5a", s, d);
    end
  endtask

  task automatic test_debug_store();
    int s, r, w; logic [31:0] d;
    do_req(1'b0, 1'b1, 32'hffff_fffe, 32'h41, s, d, r, w);
    tests++; if (w !== 1 || r !== 0) begin
      fails++; $display("FAIL dbg_traffic: writes=%0d reads=%0d, required 1/0", w, r);
    end
    tests++; if (last_waddr !== 32'hffff_fffe || last_wdata !== 128'h41) begin
      fails++; $display("FAIL dbg_bus: addr=%h data=%h, required fffffffe/41", last_waddr, last_wdata);
    end
    tests++; if (s < 1) begin fails++; $display("FAIL dbg_stall: got %0d, required >=1", s); end
    do_req(1'b1, 1'b0, 32'h18, '0, s, d, r, w);
    tests++; if (s !== 0 || d !== 32'h5a5a5a5a || r !== 0) begin
      fails++; $display("FAIL dbg_lines_kept: stall=%0d rdata=%h reads=%0d, required 0/5a5a5a5a/0", s, d, r);
    end
  endtask

  task automatic test_reset_mid_fill();
    int s, r, w; logic [31:0] d;
    memread = 1'b1; addr = 32'h20;
    @(posedge clk);
    @(posedge clk); #1;
    tests++; if (mem_read !== 1'b1 || stall !== 1'b1) begin
      fails++; $display("FAIL fill2_strobe: mem_read=%b stall=%b, required 1/1", mem_read, stall);
    end
    reset = 1'b1; memread = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if ({rdata, stall, mem_read, mem_write} !== 35'd0 || {mem_addr, mem_wdata} !== 160'd0) begin
      fails++; $display("FAIL post_reset_outs: stall=%b rd=%b wr=%b addr=%h, required all 0", stall, mem_read, mem_write, mem_addr);
    end
    @(posedge clk); #1;
    do_req(1'b1, 1'b0, 32'h20, '0, s, d, r, w);
    tests++; if (s !== 3 || d !== 32'h2) begin
      fails++; $display("FAIL reload_0x20: stall=%0d rdata=%h, required 3/00000002", s, d);
    end
    do_req(1'b1, 1'b0, 32'h14, '0, s, d, r, w);
    tests++; if (s !== 3 || d !== 32'h1) begin
      fails++; $display("FAIL invalidated_0x14: stall=%0d rdata=%h, required 3/00000001", s, d);
    end
  endtask

  task automatic test_protocol();
    tests++;
    if (viol !== 0) begin fails++; $display("FAIL protocol_count: got %0d drops, required 0", viol); end
  endtask

  initial begin
    test_reset();
    test_cold_load();
    test_store_hit();
    test_dirty_conflict();
    test_clean_conflict();
    test_debug_store();
    test_reset_mid_fill();
    test_protocol();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
